// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM states and fixed constants.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_DONE
    } div_state_e;

    localparam int unsigned DIV_STEPS  = 32;
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem, dq} left, trial-subtract
// the divisor from the widened remainder, keep or restore.
module div_step #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] dq,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] dq_next
);

    logic [DATA_W:0] rem_shift;
    logic [DATA_W:0] trial;

    // Trial subtract on DATA_W+1 bits; a clear MSB means the divisor fits.
    // On restore the shifted remainder is below the divisor, so it fits DATA_W bits.
    always_comb begin
        rem_shift = {rem, dq[DATA_W-1]};
        trial     = rem_shift - {1'b0, divisor};
        if (!trial[DATA_W]) begin
            rem_next = trial[DATA_W-1:0];
            dq_next  = {dq[DATA_W-2:0], 1'b1};
        end else begin
            rem_next = rem_shift[DATA_W-1:0];
            dq_next  = {dq[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_iter.sv
// Iterative 32-bit restoring divider (signed/unsigned) with valid/ready on
// both sides and a flush input. Fixed 33-cycle latency from accept.
module div_iter
    import div_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_signed,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    input  logic              cancel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rem_q, dq_q, dvs_q, dvd_raw_q;
    logic              qsign_q, rsign_q, dzero_q;
    logic [DATA_W-1:0] quotient_q, remainder_q;
    logic [DATA_W-1:0] rem_nx, dq_nx;
    logic              accept;
    logic              dvd_neg, dvs_neg;

    assign in_ready  = (state_q == DIV_IDLE);
    assign busy      = ~in_ready;
    assign out_valid = (state_q == DIV_DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign accept    = in_valid & in_ready & ~cancel;
    assign dvd_neg   = in_signed & dividend[DATA_W-1];
    assign dvs_neg   = in_signed & divisor[DATA_W-1];

    div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .rem      (rem_q),
        .dq       (dq_q),
        .divisor  (dvs_q),
        .rem_next (rem_nx),
        .dq_next  (dq_nx)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= DIV_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; cancel overrides both accept and the result handshake.
    always_comb begin
        state_d = state_q;
        if (cancel) begin
            state_d = DIV_IDLE;
        end else begin
            unique case (state_q)
                DIV_IDLE: if (in_valid) state_d = DIV_CALC;
                DIV_CALC: if (cnt_q == CNT_W'(DIV_STEPS)) state_d = DIV_DONE;
                DIV_DONE: if (out_ready) state_d = DIV_IDLE;
                default:  state_d = DIV_IDLE;
            endcase
        end
    end

    // Datapath: operand capture, 32 iteration steps, then one cycle for the
    // sign fix / divide-by-zero override into the output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            dq_q        <= '0;
            dvs_q       <= '0;
            dvd_raw_q   <= '0;
            qsign_q     <= 1'b0;
            rsign_q     <= 1'b0;
            dzero_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else if (accept) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            dq_q      <= dvd_neg ? ('0 - dividend) : dividend;
            dvs_q     <= dvs_neg ? ('0 - divisor) : divisor;
            dvd_raw_q <= dividend;
            qsign_q   <= dvd_neg ^ dvs_neg;
            rsign_q   <= dvd_neg;
            dzero_q   <= (divisor == '0);
        end else if (state_q == DIV_CALC && !cancel) begin
            if (cnt_q != CNT_W'(DIV_STEPS)) begin
                rem_q <= rem_nx;
                dq_q  <= dq_nx;
                cnt_q <= cnt_q + 1'b1;
            end else if (dzero_q) begin
                quotient_q  <= DATA_W'(DIV_ZERO_Q);
                remainder_q <= dvd_raw_q;
            end else begin
                quotient_q  <= qsign_q ? ('0 - dq_q) : dq_q;
                remainder_q <= rsign_q ? ('0 - rem_q) : rem_q;
            end
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: latency, signed/unsigned results, divide by
// zero, overflow, backpressure, cancel and mid-operation reset.
module tb_div_iter;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic        in_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;

    int total = 0;
    int bad   = 0;

    div_iter #(
        .DATA_W (32)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .cancel    (cancel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation, wait for the result and check latency and values.
    // If hold is set, out_ready stays low once the result appears.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_q,
                          input logic [31:0] exp_r, input logic hold);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_signed = sgn;
        dividend  = a;
        divisor   = b;
        out_ready = ~hold;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_latency"}, lat, 32'd33);
        check({tag, "_q"}, quotient, exp_q);
        check({tag, "_r"}, remainder, exp_r);
        if (!hold) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_idle_valid"}, {31'b0, out_valid}, 32'd0);
            check({tag, "_idle_ready"}, {31'b0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        int seen;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        cancel    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        resetn = 1'b1;

        run_op("u100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
        run_op("s-7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
        run_op("s7_-2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0);
        run_op("s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0);
        run_op("u_max_1",  1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0);
        run_op("s5_0",     1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b0);
        run_op("u5_0",     1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b0);
        run_op("s-5_0",    1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b0);
        run_op("u_big",    1'b0, 32'hDEAD_BEEF,  32'h0000_1000,  32'h000D_EADB,  32'h0000_0EEF,  1'b0);

        // Backpressure: result held for 10 cycles while a new request is offered.
        run_op("bp", 1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b1);
        in_valid  = 1'b1;
        dividend  = 32'd77;
        divisor   = 32'd7;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", {31'b0, out_valid}, 32'd1);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_q", quotient, 32'd30);
            check("bp_r", remainder, 32'd10);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp_drop_valid", {31'b0, out_valid}, 32'd0);
        check("bp_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("bp_no_accept", {31'b0, busy}, 32'd0);

        // Cancel at T+10, then confirm nothing emerges and a new op works.
        in_valid  = 1'b1;
        in_signed = 1'b0;
        dividend  = 32'd50;
        divisor   = 32'd5;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        cancel   = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cancel   = 1'b0;
        in_valid = 1'b0;
        check("cancel_in_ready", {31'b0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("cancel_no_valid", seen, 32'd0);
        run_op("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        // Reset at T+20 discards the operation and clears the outputs.
        @(negedge clk);
        in_valid  = 1'b1;
        dividend  = 32'd81;
        divisor   = 32'd9;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        check("rst2_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst2_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst2_busy", {31'b0, busy}, 32'd0);
        check("rst2_q", quotient, 32'd0);
        check("rst2_r", remainder, 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst2_no_valid", seen, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
